break_arbiter: RTL and testbench

- Owns the single 15-bit/12-bit memory port and shares it between the CPU major-state sequencer and NREQ data-break (DMA) requesters; RK8E is requester 0, one spare slot is reserved for a future device.
- Breaks are inserted only at CPU major-state boundaries, or at any time while the CPU is halted.
- While a break is in progress, the CPU is stalled via break_in_prog.
- A burst limiter guarantees the CPU forward progress under continuous DMA.

---
 rtl/break_arbiter_pkg.sv | 21 ++
 rtl/break_prio_sel.sv | 55 +++++
 rtl/break_arbiter.sv | 160 ++++++++++++++++
 tb/tb_break_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/break_arbiter_pkg.sv
// Shared widths and state encoding for the data-break arbiter.
// Optional rotating priority is selected with the ROUND_ROBIN_EN macro.
package break_arbiter_pkg;

  localparam int unsigned ADDR_W  = 15;
  localparam int unsigned DATA_W  = 12;
  localparam int unsigned BURST_W = 4;

  typedef enum logic [2:0] {
    BA_IDLE = 3'd0,
    BA_ARM  = 3'd1,
    BA_ADDR = 3'd2,
    BA_DATA = 3'd3,
    BA_ACK  = 3'd4
  } ba_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/break_prio_sel.sv
// Request vector -> one-hot grant and binary index of the winning requester.
// ROUND_ROBIN_EN: search starts at ptr_i; otherwise lowest index wins.
module break_prio_sel
  import break_arbiter_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned IDX_W = idx_width(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
`ifdef ROUND_ROBIN_EN
  input  logic [IDX_W-1:0] ptr_i,
`endif
  output logic [NREQ-1:0]  gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

`ifdef ROUND_ROBIN_EN
  logic        found;
  int unsigned pos;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    found   = 1'b0;
    pos     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = (32'(ptr_i) + k) % NREQ;
      if (!found && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = IDX_W'(pos);
        valid_o    = 1'b1;
      end
    end
  end
`else
  // Scan from the top so the lowest requesting index is the last one written.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned k = NREQ; k > 0; k--) begin
      if (req_i[k-1]) begin
        gnt_o        = '0;
        gnt_o[k-1]   = 1'b1;
        idx_o        = IDX_W'(k - 1);
        valid_o      = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/break_arbiter.sv
// Memory-port owner: inserts NREQ data breaks between CPU major states with a burst limiter.
// ROUND_ROBIN_EN selects rotating priority among requesters; default is fixed priority.
module break_arbiter
  import break_arbiter_pkg::*;
#(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     cpu_boundary,
  input  logic                     cpu_halted,
  input  logic [NREQ-1:0]          dev_req,
  input  logic [NREQ-1:0]          dev_write,
  input  logic [ADDR_W*NREQ-1:0]   dev_addr,
  input  logic [DATA_W*NREQ-1:0]   dev_wdata,
  output logic [NREQ-1:0]          dev_ack,
  output logic [DATA_W-1:0]        dev_rdata,
  output logic                     break_in_prog,
  output logic                     mem_sel,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_we,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int unsigned IDX_W = idx_width(NREQ);

  ba_state_e          state_q, state_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               write_q, write_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               clr_pend_q, clr_pend_d;
`ifdef ROUND_ROBIN_EN
  logic [IDX_W-1:0]   rr_q, rr_d;
`endif

  logic [NREQ-1:0]    sel_gnt;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_valid;
  logic               blocked;
  logic               grant;
  logic               busy;

  break_prio_sel #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_prio (
    .req_i   (dev_req),
`ifdef ROUND_ROBIN_EN
    .ptr_i   (rr_q),
`endif
    .gnt_o   (sel_gnt),
    .idx_o   (sel_idx),
    .valid_o (sel_valid)
  );

  assign blocked = !cpu_halted && (burst_q == BURST_W'(MAX_BURST));
  assign grant   = (state_q == BA_IDLE) && sel_valid
                   && (cpu_boundary || cpu_halted) && !blocked;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    rdata_d    = rdata_q;
    burst_d    = burst_q;
    clr_pend_d = clr_pend_q;
`ifdef ROUND_ROBIN_EN
    rr_d       = rr_q;
`endif
    unique case (state_q)
      BA_IDLE: begin
        if (grant) begin
          state_d = BA_ARM;
          gnt_d   = sel_gnt;
          addr_d  = dev_addr[ADDR_W*sel_idx +: ADDR_W];
          wdata_d = dev_wdata[DATA_W*sel_idx +: DATA_W];
          write_d = dev_write[sel_idx];
`ifdef ROUND_ROBIN_EN
          rr_d    = (sel_idx == IDX_W'(NREQ - 1)) ? '0 : sel_idx + IDX_W'(1);
`endif
        end
        // A boundary not taken by a break is a CPU major state: burst restarts.
        if (cpu_halted || (cpu_boundary && !grant) || clear) burst_d = '0;
`ifdef ROUND_ROBIN_EN
        if (clear) rr_d = '0;
`endif
        clr_pend_d = 1'b0;
      end
      BA_ARM: begin
        state_d = BA_ADDR;
        if (clear) clr_pend_d = 1'b1;
      end
      BA_ADDR: begin
        state_d = BA_DATA;
        if (clear) clr_pend_d = 1'b1;
      end
      BA_DATA: begin
        state_d = BA_ACK;
        if (!write_q) rdata_d = mem_rdata;
        if (clear) clr_pend_d = 1'b1;
      end
      BA_ACK: begin
        state_d = BA_IDLE;
        if (clr_pend_q || clear || cpu_halted) burst_d = '0;
        else                                   burst_d = burst_q + BURST_W'(1);
`ifdef ROUND_ROBIN_EN
        if (clr_pend_q || clear) rr_d = '0;
`endif
        clr_pend_d = 1'b0;
      end
      default: state_d = BA_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= BA_IDLE;
      gnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      rdata_q    <= '0;
      burst_q    <= '0;
      clr_pend_q <= 1'b0;
`ifdef ROUND_ROBIN_EN
      rr_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      rdata_q    <= rdata_d;
      burst_q    <= burst_d;
      clr_pend_q <= clr_pend_d;
`ifdef ROUND_ROBIN_EN
      rr_q       <= rr_d;
`endif
    end
  end

  assign busy          = (state_q != BA_IDLE);
  assign break_in_prog = busy;
  assign mem_sel       = busy;
  assign mem_addr      = busy ? addr_q : '0;
  assign mem_wdata     = (busy && write_q) ? wdata_q : '0;
  assign mem_we        = (state_q == BA_ADDR) && write_q;
  assign dev_ack       = (state_q == BA_ACK) ? gnt_q : '0;
  assign dev_rdata     = rdata_q;

endmodule

// File: tb/tb_break_arbiter.sv
// Scoreboard bench for break_arbiter; honours ROUND_ROBIN_EN for contention expectations.
module tb_break_arbiter;
  import break_arbiter_pkg::*;

  localparam int unsigned NREQ      = 2;
  localparam int unsigned MAX_BURST = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset, clear, cpu_boundary, cpu_halted;
  logic [NREQ-1:0]    dev_req, dev_write, dev_ack;
  logic [15*NREQ-1:0] dev_addr;
  logic [12*NREQ-1:0] dev_wdata;
  logic [11:0]        dev_rdata, mem_wdata, mem_rdata;
  logic               break_in_prog, mem_sel, mem_we;
  logic [14:0]        mem_addr;

  logic [11:0] ram [0:32767];
  logic        pre_en;
  logic [14:0] pre_addr;
  logic [11:0] pre_data;

  always @(posedge clk) begin
    if (pre_en) ram[pre_addr] <= pre_data;
    else if (mem_sel && mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  break_arbiter #(.NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset), .clear(clear), .cpu_boundary(cpu_boundary),
    .cpu_halted(cpu_halted), .dev_req(dev_req), .dev_write(dev_write),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_ack(dev_ack),
    .dev_rdata(dev_rdata), .break_in_prog(break_in_prog), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    int unsigned dev;
    logic [14:0] addr;
    logic [11:0] data;
  } exp_t;

  exp_t sbq[$];
  bit   gq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic exp_t mk_exp(input int unsigned d, input logic [14:0] a, input logic [11:0] v);
    exp_t e;
    e.dev = d; e.addr = a; e.data = v;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int unsigned d, input logic wr, input logic [14:0] a, input logic [11:0] w);
    dev_write[d]         = wr;
    dev_addr[15*d +: 15] = a;
    dev_wdata[12*d +: 12] = w;
  endtask

  task automatic wait_ack(input int budget, output bit got, output logic [1:0] vec,
                          output logic [11:0] rd, output int lat, output int bip,
                          output int wes, output logic [14:0] wa, output logic [11:0] wd);
    got = 1'b0; vec = '0; rd = '0; lat = 0; bip = 0; wes = 0; wa = '0; wd = '0;
    for (int i = 1; i <= budget; i++) begin
      tick();
      cpu_boundary = 1'b0;
      if (break_in_prog) bip++;
      if (mem_we) begin wes++; wa = mem_addr; wd = mem_wdata; end
      if (dev_ack != '0) begin
        got = 1'b1; vec = dev_ack; rd = dev_rdata; lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    n_vec++; if (break_in_prog !== 1'b0) begin n_bad++; $display("FAIL reset_bip: got %0b want 0", break_in_prog); end
    n_vec++; if (mem_sel !== 1'b0) begin n_bad++; $display("FAIL reset_mem_sel: got %0b want 0", mem_sel); end
    n_vec++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_mem_we: got %0b want 0", mem_we); end
    n_vec++; if (dev_ack !== 2'b00) begin n_bad++; $display("FAIL reset_ack: got %0b want 0", dev_ack); end
    n_vec++; if (dev_rdata !== 12'o0) begin n_bad++; $display("FAIL reset_rdata: got %0o want 0", dev_rdata); end
    n_vec++; if (mem_addr !== 15'o0) begin n_bad++; $display("FAIL reset_addr: got %0o want 0", mem_addr); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_write();
    bit got; logic [1:0] vec, ev; logic [11:0] rd, wd; int lat, bip, wes; logic [14:0] wa; exp_t e;
    set_slot(0, 1'b1, 15'o07200, 12'o1234);
    dev_req = 2'b01; cpu_boundary = 1'b1;
    sbq.push_back(mk_exp(0, 15'o07200, 12'o1234));
    wait_ack(10, got, vec, rd, lat, bip, wes, wa, wd);
    dev_req = 2'b00;
    e = sbq.pop_front(); ev = 2'b01 << e.dev;
    n_vec++; if (vec !== ev) begin n_bad++; $display("FAIL write_ack_vec: got %0b want %0b", vec, ev); end
    n_vec++; if (lat !== 4) begin n_bad++; $display("FAIL write_latency: got %0d want 4", lat); end
    n_vec++; if (bip !== 4) begin n_bad++; $display("FAIL write_bip_cycles: got %0d want 4", bip); end
    n_vec++; if (wes !== 1) begin n_bad++; $display("FAIL write_we_cycles: got %0d want 1", wes); end
    n_vec++; if (wa !== e.addr) begin n_bad++; $display("FAIL write_addr: got %0o want %0o", wa, e.addr); end
    n_vec++; if (wd !== e.data) begin n_bad++; $display("FAIL write_data: got %0o want %0o", wd, e.data); end
    tick();
    n_vec++; if (break_in_prog !== 1'b0) begin n_bad++; $display("FAIL write_bip_drop: got %0b want 0", break_in_prog); end
    n_vec++; if (ram[15'o07200] !== 12'o1234) begin n_bad++; $display("FAIL write_ram: got %0o want 1234", ram[15'o07200]); end
  endtask

  task automatic test_read();
    bit got; logic [1:0] vec, ev; logic [11:0] rd, wd; int lat, bip, wes; logic [14:0] wa; exp_t e;
    pre_en = 1'b1; pre_addr = 15'o10010; pre_data = 12'o5555;
    tick();
    pre_en = 1'b0;
    set_slot(1, 1'b0, 15'o10010, 12'o7777);
    dev_req = 2'b10; cpu_boundary = 1'b1;
    sbq.push_back(mk_exp(1, 15'o10010, 12'o5555));
    wait_ack(10, got, vec, rd, lat, bip, wes, wa, wd);
    dev_req = 2'b00;
    e = sbq.pop_front(); ev = 2'b01 << e.dev;
    n_vec++; if (vec !== ev) begin n_bad++; $display("FAIL read_ack_vec: got %0b want %0b", vec, ev); end
    n_vec++; if (rd !== e.data) begin n_bad++; $display("FAIL read_rdata: got %0o want %0o", rd, e.data); end
    n_vec++; if (wes !== 0) begin n_bad++; $display("FAIL read_we_cycles: got %0d want 0", wes); end
    n_vec++; if (lat !== 4) begin n_bad++; $display("FAIL read_latency: got %0d want 4", lat); end
    tick();
    n_vec++; if (dev_rdata !== 12'o5555) begin n_bad++; $display("FAIL read_hold: got %0o want 5555", dev_rdata); end
  endtask

  task automatic test_contention();
    bit got; logic [1:0] vec, ev; logic [11:0] rd, wd; int lat, bip, wes; logic [14:0] wa; exp_t e;
    int unsigned d;
    clear = 1'b1; tick(); clear = 1'b0;
    set_slot(0, 1'b1, 15'o00100, 12'o0100);
    set_slot(1, 1'b1, 15'o00200, 12'o0200);
    for (int k = 0; k < 6; k++) begin
`ifdef ROUND_ROBIN_EN
      d = k % 2;
`else
      d = 0;
`endif
      sbq.push_back(mk_exp(d, (d == 0) ? 15'o00100 : 15'o00200, (d == 0) ? 12'o0100 : 12'o0200));
    end
    for (int k = 0; k < 6; k++) begin
      dev_req = 2'b11; cpu_boundary = 1'b1;
      wait_ack(10, got, vec, rd, lat, bip, wes, wa, wd);
      dev_req = 2'b00;
      e = sbq.pop_front(); ev = 2'b01 << e.dev;
      n_vec++; if (vec !== ev) begin n_bad++; $display("FAIL contention_grant[%0d]: got %0b want %0b", k, vec, ev); end
      n_vec++; if (wa !== e.addr) begin n_bad++; $display("FAIL contention_addr[%0d]: got %0o want %0o", k, wa, e.addr); end
      tick();
      cpu_boundary = 1'b1;   // CPU runs a major state between breaks
      tick();
      cpu_boundary = 1'b0;
    end
  endtask

  task automatic test_burst_limit();
    bit got; logic [1:0] vec; logic [11:0] rd, wd; int lat, bip, wes; logic [14:0] wa;
    bit exp_g; int nb;
    clear = 1'b1; tick(); clear = 1'b0;
    set_slot(0, 1'b1, 15'o00300, 12'o0300);
    dev_req = 2'b01;
    nb = 0;
    for (int cyc = 0; cyc < 200 && nb < 12; cyc++) begin
      if (!break_in_prog) begin
        cpu_boundary = 1'b1;
        gq.push_back((nb % 5) != 4);
        nb++;
        tick();
        cpu_boundary = 1'b0;
        exp_g = gq.pop_front();
        n_vec++; if (break_in_prog !== exp_g) begin n_bad++; $display("FAIL burst_grant[%0d]: got %0b want %0b", nb - 1, break_in_prog, exp_g); end
      end else begin
        tick();
      end
    end
    n_vec++; if (nb !== 12) begin n_bad++; $display("FAIL burst_boundaries: got %0d want 12", nb); end
    cpu_halted = 1'b1;
    wait_ack(10, got, vec, rd, lat, bip, wes, wa, wd);
    n_vec++; if (got !== 1'b1) begin n_bad++; $display("FAIL halted_drain: got %0b want 1", got); end
    for (int k = 0; k < 8; k++) begin
      wait_ack(12, got, vec, rd, lat, bip, wes, wa, wd);
      n_vec++; if (lat !== 5) begin n_bad++; $display("FAIL halted_b2b[%0d]: got gap %0d want 5", k, lat); end
    end
    dev_req = 2'b00; cpu_halted = 1'b0;
    tick();
  endtask

  task automatic test_clear_mid_break();
    bit got; logic [1:0] vec; logic [11:0] rd, wd; int lat, bip, wes; logic [14:0] wa;
    clear = 1'b1; tick(); clear = 1'b0;
    set_slot(0, 1'b1, 15'o00400, 12'o4321);
    for (int k = 0; k < 3; k++) begin
      dev_req = 2'b01; cpu_boundary = 1'b1;
      wait_ack(10, got, vec, rd, lat, bip, wes, wa, wd);
      dev_req = 2'b00;
      n_vec++; if (got !== 1'b1) begin n_bad++; $display("FAIL clear_pre[%0d]: got %0b want 1", k, got); end
      tick();
    end
    set_slot(0, 1'b1, 15'o00500, 12'o6543);
    dev_req = 2'b01; cpu_boundary = 1'b1;
    tick(); cpu_boundary = 1'b0;
    tick();
    n_vec++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL clear_in_addr: got we %0b want 1", mem_we); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    wait_ack(10, got, vec, rd, lat, bip, wes, wa, wd);
    dev_req = 2'b00;
    n_vec++; if (vec !== 2'b01) begin n_bad++; $display("FAIL clear_ack: got %0b want 01", vec); end
    tick();
    n_vec++; if (ram[15'o00500] !== 12'o6543) begin n_bad++; $display("FAIL clear_write: got %0o want 6543", ram[15'o00500]); end
    for (int k = 0; k < 4; k++) begin
      dev_req = 2'b01; cpu_boundary = 1'b1;
      wait_ack(10, got, vec, rd, lat, bip, wes, wa, wd);
      dev_req = 2'b00;
      n_vec++; if (got !== 1'b1) begin n_bad++; $display("FAIL clear_post_grant[%0d]: got %0b want 1", k, got); end
      tick();
    end
    dev_req = 2'b01; cpu_boundary = 1'b1;
    tick();
    cpu_boundary = 1'b0; dev_req = 2'b00;
    n_vec++; if (break_in_prog !== 1'b0) begin n_bad++; $display("FAIL clear_post_block: got %0b want 0", break_in_prog); end
    tick();
  endtask

  task automatic test_reset_mid_break();
    bit got; logic [1:0] vec; logic [11:0] rd, wd; int lat, bip, wes; logic [14:0] wa;
    pre_en = 1'b1; pre_addr = 15'o00600; pre_data = 12'o1111;
    tick();
    pre_en = 1'b0;
    set_slot(1, 1'b0, 15'o00600, 12'o0);
    dev_req = 2'b10; cpu_boundary = 1'b1;
    tick(); cpu_boundary = 1'b0;
    tick();
    tick();
    n_vec++; if (break_in_prog !== 1'b1) begin n_bad++; $display("FAIL rst_mid_busy: got %0b want 1", break_in_prog); end
    reset = 1'b0;
    tick();
    n_vec++; if (mem_sel !== 1'b0) begin n_bad++; $display("FAIL rst_mid_sel: got %0b want 0", mem_sel); end
    n_vec++; if (break_in_prog !== 1'b0) begin n_bad++; $display("FAIL rst_mid_bip: got %0b want 0", break_in_prog); end
    n_vec++; if (dev_ack !== 2'b00) begin n_bad++; $display("FAIL rst_mid_ack: got %0b want 0", dev_ack); end
    n_vec++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mid_we: got %0b want 0", mem_we); end
    n_vec++; if (dev_rdata !== 12'o0) begin n_bad++; $display("FAIL rst_mid_rdata: got %0o want 0", dev_rdata); end
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_vec++; if ({break_in_prog, dev_ack} !== 3'b000) begin n_bad++; $display("FAIL rst_mid_idle[%0d]: got bip %0b ack %0b want 0 0", k, break_in_prog, dev_ack); end
    end
    cpu_boundary = 1'b1;
    wait_ack(10, got, vec, rd, lat, bip, wes, wa, wd);
    dev_req = 2'b00;
    n_vec++; if (lat !== 4) begin n_bad++; $display("FAIL rst_mid_relat: got %0d want 4", lat); end
    n_vec++; if (rd !== 12'o1111) begin n_bad++; $display("FAIL rst_mid_reread: got %0o want 1111", rd); end
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; clear = 1'b0; cpu_boundary = 1'b0; cpu_halted = 1'b0;
    dev_req = '0; dev_write = '0; dev_addr = '0; dev_wdata = '0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    test_reset();
    test_write();
    test_read();
    test_contention();
    test_burst_limit();
    test_clear_mid_break();
    test_reset_mid_break();
    n_vec++; if (sbq.size() !== 0) begin n_bad++; $display("FAIL sb_drained: got %0d entries want 0", sbq.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
